// File: rtl/nv_nvdla_csb_master_gray_ptr_fifo.sv
// Single-clock FIFO for CSB request payloads to falcon. The read and write pointers are
// registered Gray counters, so they can be handed to a synchronizer later without glitches.
module nv_nvdla_csb_master_gray_ptr_fifo #(
    parameter int unsigned PTR_W = 3,
    parameter int unsigned DW    = 32
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [DW-1:0]    wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [DW-1:0]    rd_pd,
    output logic [PTR_W-1:0] wr_ptr_gray,
    output logic [PTR_W-1:0] rd_ptr_gray,
    output logic [PTR_W-1:0] fifo_count
);

    localparam int unsigned AW    = PTR_W - 1;
    localparam int unsigned DEPTH = 2 ** AW;

    // The write pointer is one lap ahead of the read pointer: in Gray code the top two
    // bits are inverted and the rest are equal.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    // Even parity flips bit 0. Odd parity flips the bit just above the lowest set bit.
    // If the lowest set bit is the MSB, the MSB is flipped and the pointer wraps to zero.
    function automatic logic [PTR_W-1:0] gray_inc(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] r;
        logic             found;
        r     = g;
        found = 1'b0;
        if (^g == 1'b0) begin
            r[0] = ~g[0];
        end else begin
            for (int i = 0; i < int'(PTR_W) - 1; i++) begin
                if (!found && g[i]) begin
                    r[i+1] = ~g[i+1];
                    found  = 1'b1;
                end
            end
            if (!found) begin
                r[PTR_W-1] = ~g[PTR_W-1];
            end
        end
        return r;
    endfunction

    // Storage address is the low bits of the binary equivalent of the pointer.
    function automatic logic [AW-1:0] gray2addr(input logic [PTR_W-1:0] g);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(AW); i++) begin
            a[i] = ^(g >> i);
        end
        return a;
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [DW-1:0]    mem_q [DEPTH];

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    // Handshake outputs are functions of the registered pointers only.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q == (rd_ptr_q ^ FULL_MASK));

    assign wr_prdy = ~full;
    assign rd_pvld = ~empty;
    assign push    = wr_pvld & ~full;
    assign pop     = rd_prdy & ~empty;

    assign wr_addr = gray2addr(wr_ptr_q);
    assign rd_addr = gray2addr(rd_ptr_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + PTR_W'(push) - PTR_W'(pop);
        if (push) begin
            wr_ptr_d = gray_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = gray_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rst && push) begin
            mem_q[wr_addr] <= wr_pd;
        end
    end

    assign rd_pd       = mem_q[rd_addr];
    assign wr_ptr_gray = wr_ptr_q;
    assign rd_ptr_gray = rd_ptr_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_nv_nvdla_csb_master_gray_ptr_fifo.sv
// Bench for the Gray-pointer FIFO: directed scenarios followed by random traffic. Every
// cycle is compared against a queue-based reference model.
module tb_nv_nvdla_csb_master_gray_ptr_fifo;

    localparam int unsigned PTR_W = 3;
    localparam int unsigned DW    = 32;
    localparam int          DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_pvld = 1'b0;
    logic             wr_prdy;
    logic [DW-1:0]    wr_pd = '0;
    logic             rd_pvld;
    logic             rd_prdy = 1'b0;
    logic [DW-1:0]    rd_pd;
    logic [PTR_W-1:0] wr_ptr_gray;
    logic [PTR_W-1:0] rd_ptr_gray;
    logic [PTR_W-1:0] fifo_count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    logic [DW-1:0] model_q[$];
    int            wr_cnt = 0;
    int            rd_cnt = 0;

    always #5 clk = ~clk;

    nv_nvdla_csb_master_gray_ptr_fifo #(
        .PTR_W(PTR_W),
        .DW   (DW)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .wr_pvld       (wr_pvld),
        .wr_prdy       (wr_prdy),
        .wr_pd         (wr_pd),
        .rd_pvld       (rd_pvld),
        .rd_prdy       (rd_prdy),
        .rd_pd         (rd_pd),
        .wr_ptr_gray   (wr_ptr_gray),
        .rd_ptr_gray   (rd_ptr_gray),
        .fifo_count    (fifo_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PTR_W-1:0] to_gray(input int n);
        logic [PTR_W-1:0] b;
        b = PTR_W'(n % (2 ** PTR_W));
        return b ^ (b >> 1);
    endfunction

    // Apart from a reset, each pointer may change by at most one bit per clock.
    logic [PTR_W-1:0] wr_prev, rd_prev;
    logic             prev_valid = 1'b0;
    logic             rst_seen   = 1'b1;
    always @(posedge clk) begin
        if (prev_valid && !rst_seen) begin
            assert ($countones(wr_ptr_gray ^ wr_prev) <= 1)
            else $error("FAIL wr_gray_step: %b -> %b", wr_prev, wr_ptr_gray);
            assert ($countones(rd_ptr_gray ^ rd_prev) <= 1)
            else $error("FAIL rd_gray_step: %b -> %b", rd_prev, rd_ptr_gray);
            check_eq("wr_gray_step", 32'($countones(wr_ptr_gray ^ wr_prev) <= 1), 32'd1);
            check_eq("rd_gray_step", 32'($countones(rd_ptr_gray ^ rd_prev) <= 1), 32'd1);
        end
        wr_prev    <= wr_ptr_gray;
        rd_prev    <= rd_ptr_gray;
        rst_seen   <= rst;
        prev_valid <= 1'b1;
    end

    task automatic check_all();
        check_eq("rd_pvld", 32'(rd_pvld), 32'(model_q.size() != 0));
        check_eq("wr_prdy", 32'(wr_prdy), 32'(model_q.size() < DEPTH));
        check_eq("fifo_count", 32'(fifo_count), 32'(model_q.size()));
        check_eq("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(wr_cnt)));
        check_eq("rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(rd_cnt)));
        if (model_q.size() != 0) begin
            check_eq("rd_pd", rd_pd, model_q[0]);
        end
    endtask

    // Drive one cycle of inputs, clock it through, update the model and check.
    task automatic cycle(input logic r, input logic wv, input logic [DW-1:0] d, input logic rv);
        logic do_push, do_pop;
        rst     = r;
        wr_pvld = wv;
        wr_pd   = d;
        rd_prdy = rv;
        do_push = !r && wv && (model_q.size() < DEPTH);
        do_pop  = !r && rv && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
            wr_cnt = 0;
            rd_cnt = 0;
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                rd_cnt++;
            end
            if (do_push) begin
                model_q.push_back(d);
                wr_cnt++;
            end
        end
        check_all();
    endtask

    initial begin
        // 1: reset held two cycles with a push request pending.
        cycle(1'b1, 1'b1, 32'hDEAD_0001, 1'b0);
        cycle(1'b1, 1'b1, 32'hDEAD_0002, 1'b0);
        check_eq("reset_wr_ptr", 32'(wr_ptr_gray), 32'd0);
        check_eq("reset_rd_pvld", 32'(rd_pvld), 32'd0);

        // 2: fill to capacity, then a fifth push is dropped.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0);
        end
        check_eq("fill_wr_ptr", 32'(wr_ptr_gray), 32'b110);
        check_eq("fill_count", 32'(fifo_count), 32'd4);
        cycle(1'b0, 1'b1, 32'hA4, 1'b0);
        check_eq("full_wr_prdy", 32'(wr_prdy), 32'd0);

        // 3: drain in order.
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_rd_pd", rd_pd, 32'hA0 + 32'(i));
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end
        check_eq("drain_rd_ptr", 32'(rd_ptr_gray), 32'b110);
        check_eq("drain_empty", 32'(rd_pvld), 32'd0);

        // 4: twenty push/pop pairs at occupancy one wrap both pointers.
        cycle(1'b0, 1'b1, 32'hB000_0000, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 1'b1);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // 5: at full, push+pop pops only; the next cycle both are accepted.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
        end
        cycle(1'b0, 1'b1, 32'hC4, 1'b1);
        check_eq("full_pp_count", 32'(fifo_count), 32'd3);
        cycle(1'b0, 1'b1, 32'hC5, 1'b1);
        check_eq("pp_count", 32'(fifo_count), 32'd3);

        // 6: reset mid-stream wins over push and pop.
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("pre_rst_count", 32'(fifo_count), 32'd2);
        cycle(1'b1, 1'b1, 32'hEE, 1'b1);
        check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
        check_eq("mid_rst_rd_pvld", 32'(rd_pvld), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(63) == 0, $urandom_range(99) < 60, $urandom,
                  $urandom_range(99) < 50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
